dmux_scheduler: RTL and testbench

DMUX_SCHEDULER -- requirements
Module: dmux_scheduler

---
 rtl/dmux_scheduler.sv | 73 +++++++
 tb/tb_dmux_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dmux_scheduler.sv
// Single-entry demultiplexing scheduler: accepts one word, then steers it to one of four
// channels, either round-robin or to a fixed channel chosen per word.
module dmux_scheduler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             mode,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [15:0]      delivered
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hold_data_q;
  logic [1:0]       hold_dst_q;
  logic [1:0]       rr_ptr_q;
  logic [15:0]      delivered_q;

  logic in_fire;
  logic out_fire;

  // Only the held word's own channel can release it; other ready bits are ignored.
  assign out_fire = (state_q == StFull) && out_ready[hold_dst_q];
  assign in_ready = (state_q == StEmpty) || out_fire;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      hold_data_q <= '0;
      hold_dst_q  <= 2'd0;
      rr_ptr_q    <= 2'd0;
      delivered_q <= 16'd0;
    end else begin
      if (out_fire) begin
        delivered_q <= delivered_q + 16'd1;
      end
      if (in_fire) begin
        state_q     <= StFull;
        hold_data_q <= in_data;
        if (mode) begin
          hold_dst_q <= in_sel;
        end else begin
          hold_dst_q <= rr_ptr_q;
          rr_ptr_q   <= rr_ptr_q + 2'd1;
        end
      end else if (out_fire) begin
        state_q <= StEmpty;
      end
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    if (state_q == StFull) begin
      out_valid[hold_dst_q] = 1'b1;
    end
  end

  assign out_data  = hold_data_q;
  assign busy      = (state_q == StFull);
  assign delivered = delivered_q;

endmodule

// File: tb/tb_dmux_scheduler.sv
// Directed bench for dmux_scheduler: round-robin, stall, fixed mode, simultaneous fire,
// mid-transfer reset and delivery counter wrap.
module tb_dmux_scheduler;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             mode;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic [15:0]      delivered;

  int checks   = 0;
  int failures = 0;

  dmux_scheduler #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .delivered (delivered)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    mode      = 1'b0;
    out_ready = 4'b0000;
    tick();
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_delivered", delivered, 16'h0000);
    chk("rst_out_data", out_data, 16'h0000);
    reset = 1'b0;

    // Round-robin, back-to-back 0x0001..0x0005
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_data = 16'h0001; tick();
    chk("rr1_valid", out_valid, 4'b0001); chk("rr1_data", out_data, 16'h0001);
    in_data = 16'h0002; tick();
    chk("rr2_valid", out_valid, 4'b0010); chk("rr2_data", out_data, 16'h0002);
    chk("rr2_deliv", delivered, 16'd1);
    in_data = 16'h0003; tick();
    chk("rr3_valid", out_valid, 4'b0100); chk("rr3_data", out_data, 16'h0003);
    in_data = 16'h0004; tick();
    chk("rr4_valid", out_valid, 4'b1000); chk("rr4_data", out_data, 16'h0004);
    in_data = 16'h0005; tick();
    chk("rr5_valid", out_valid, 4'b0001); chk("rr5_data", out_data, 16'h0005);
    chk("rr5_busy", busy, 1'b1);
    in_valid = 1'b0; tick();
    chk("rr_deliv", delivered, 16'd5);
    chk("rr_idle_valid", out_valid, 4'b0000);
    chk("rr_idle_busy", busy, 1'b0);

    // Stall on channel 1 after a reset returns the pointer to 0
    pulse_reset();
    chk("stall_rst_deliv", delivered, 16'd0);
    out_ready = 4'b1101;
    in_valid = 1'b1; in_data = 16'hAAAA; tick();
    chk("stall_a_valid", out_valid, 4'b0001);
    chk("stall_a_ready", in_ready, 1'b1);
    in_data = 16'hBBBB; tick();
    chk("stall_b_valid", out_valid, 4'b0010);
    chk("stall_b_data", out_data, 16'hBBBB);
    chk("stall_b_ready", in_ready, 1'b0);
    chk("stall_b_deliv", delivered, 16'd1);
    in_data = 16'hCCCC; tick();
    chk("stall_hold_data", out_data, 16'hBBBB);
    chk("stall_hold_busy", busy, 1'b1);
    in_valid = 1'b0; mode = 1'b1; in_sel = 2'd3; tick();
    chk("stall_mode_chg_valid", out_valid, 4'b0010);
    mode = 1'b0; out_ready = 4'b1111; #1;
    chk("stall_release_ready", in_ready, 1'b1);
    tick();
    chk("stall_done_deliv", delivered, 16'd2);
    chk("stall_done_busy", busy, 1'b0);

    // Fixed mode to channel 2; pointer (2) must not advance
    mode = 1'b1; in_sel = 2'd2; in_valid = 1'b1; in_data = 16'h1234; tick();
    chk("fix_valid", out_valid, 4'b0100);
    chk("fix_data", out_data, 16'h1234);
    mode = 1'b0; in_sel = 2'd0; in_data = 16'h4321; tick();
    chk("fix_next_valid", out_valid, 4'b0100);
    chk("fix_next_data", out_data, 16'h4321);
    chk("fix_deliv", delivered, 16'd3);

    // Simultaneous output and input fire on channel 3
    in_data = 16'h7777; tick();
    chk("sim_pre_valid", out_valid, 4'b1000);
    out_ready = 4'b1000; in_data = 16'h8888; #1;
    chk("sim_in_ready", in_ready, 1'b1);
    tick();
    chk("sim_busy", busy, 1'b1);
    chk("sim_valid", out_valid, 4'b0001);
    chk("sim_data", out_data, 16'h8888);
    chk("sim_deliv", delivered, 16'd5);
    in_valid = 1'b0; out_ready = 4'b0000; tick();
    chk("sim_hold_valid", out_valid, 4'b0001);

    // Reset while holding 0x5555 for channel 1
    out_ready = 4'b1111; in_valid = 1'b1; in_data = 16'h5555; tick();
    in_valid = 1'b0; out_ready = 4'b0000; tick();
    chk("mid_pre_valid", out_valid, 4'b0010);
    chk("mid_pre_data", out_data, 16'h5555);
    #2 reset = 1'b1; #1;
    chk("mid_rst_valid", out_valid, 4'b0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_deliv", delivered, 16'd0);
    chk("mid_rst_ready", in_ready, 1'b1);
    reset = 1'b0;
    in_valid = 1'b1; in_data = 16'h9999; tick();
    chk("mid_next_valid", out_valid, 4'b0001);
    chk("mid_next_data", out_data, 16'h9999);
    in_valid = 1'b0; out_ready = 4'b1111; tick();
    chk("mid_next_deliv", delivered, 16'd1);

    // Counter wrap after 65536 deliveries
    pulse_reset();
    in_valid = 1'b1; out_ready = 4'b1111; in_data = 16'h0F0F;
    repeat (65536) tick();
    chk("wrap_ffff", delivered, 16'hFFFF);
    chk("wrap_busy", busy, 1'b1);
    in_valid = 1'b0; tick();
    chk("wrap_zero", delivered, 16'h0000);
    chk("wrap_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
